lnrv_exu_excp_arb: RTL and testbench
====================================

Name: lnrv_exu_excp_arb

Overview:
Parametrised, registered exception/interrupt arbiter for the lnrv EXU. It accepts up to NUM_SRC synchronous exception sources (decode, LSU, sys, and others) plus one interrupt request. It captures the winner in a holding register and then runs a flush/commit handshake. On that handshake it updates the M-mode trap CSRs, or enters debug mode for ebreak. Added over the previous generation: arbitrary source count, registered capture, interrupts, and mtvec vectored mode.

Parameters:
NUM_SRC, 3, number of exception sources; index 0 has the highest priority.
XLEN, 32, data/address width.
DBG_ENTRY, 32'h800, flush target for ebreak entering debug mode.
DBG_EXCP, 32'h808, flush target for any trap taken while d_mode=1.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
src_excp_vld  in  NUM_SRC  per-source exception valid
src_excp_rdy  out  NUM_SRC  per-source accept (one-hot or zero)
src_excp_cause  in  4*NUM_SRC  per-source mcause code; source i uses bits [4i+3:4i]
src_excp_tval  in  XLEN*NUM_SRC  per-source mtval value
src_excp_ebreak  in  NUM_SRC  source exception is an ebreak
irq_vld  in  1  interrupt pending
irq_rdy  out  1  interrupt accepted
irq_cause  in  4  interrupt code
pc  in  XLEN  pc of the instruction at the commit point
d_mode  in  1  core is in debug mode
dcsr_ebreakm  in  1  ebreak enters debug mode when d_mode=0
mtvec  in  XLEN  trap vector; [1:0]=mode, [XLEN-1:2]=base
cmt_csr  out  1  one-cycle pulse: write mepc/mcause/mtval
cmt_mepc  out  XLEN  captured pc
cmt_mcause  out  XLEN  {intr, zeros, code[3:0]}
cmt_mtval  out  XLEN  captured tval (0 for interrupts)
cmt_dcsr  out  1  one-cycle pulse: write dpc/dcause
cmt_dpc  out  XLEN  captured pc
cmt_dcause  out  3  fixed 3'd2 (ebreak)
pipe_flush_req  out  1  flush request
pipe_flush_ack  in  1  flush acknowledge
pipe_flush_pc_op1  out  XLEN  flush target
pipe_flush_pc_op2  out  XLEN  constant 0
busy  out  1  FSM is not IDLE

Behaviour:
- FSM states: IDLE and FLUSH. On reset: IDLE; all holding registers 0; every output 0, except cmt_dcause=3'd2.
- IDLE arbitration (combinational):
  - Winner = lowest set index of src_excp_vld.
  - If no source is valid and irq_vld=1, the interrupt wins. Exceptions always beat interrupts.
- Capture: in IDLE with a winner, assert only that winner's rdy (src_excp_rdy[i] or irq_rdy) in the same cycle. On the next edge:
  - Latch pc, code, tval (0 for interrupts), intr flag and ebreak flag.
  - Latch dbg = ebreak & ~d_mode & dcsr_ebreakm.
  - Latch target:
    - dbg: DBG_ENTRY.
    - else d_mode: DBG_EXCP.
    - else interrupt with mtvec[1:0]==2'b01: {base,2'b00} + 4*code, truncated to XLEN.
    - else: {base,2'b00}.
  - Go to FLUSH.
- All rdy outputs are 0 outside IDLE, so a new request waits.
- FLUSH:
  - pipe_flush_req=1, with pipe_flush_pc_op1 = latched target, held stable until ack.
  - Handshake cycle (req & ack): cmt_csr = ~dbg and cmt_dcsr = dbg, as combinational pulses. Return to IDLE on the same edge.
  - Ack while in IDLE is ignored.
- Latency: request in cycle N, rdy in N, flush_req first high in N+1. With ack in N+1, back in IDLE at N+2, where a new capture is possible (rdy again in N+2).
- cmt_mepc, cmt_mcause, cmt_mtval, cmt_dpc are driven from the holding registers and are valid whenever busy=1.
- Source inputs changing during FLUSH do not affect the outputs.
- A reset asserted mid-FLUSH aborts the trap with no commit pulse.

Test Plan:
- Only src 1 valid, cause 4, tval 32'h1003, pc 32'h200, mtvec 32'h1000, ack one cycle after req -> rdy=3'b010 for one cycle; flush_req for 1 cycle with op1 32'h1000; cmt_csr pulse with mepc 32'h200, mcause 4, mtval 32'h1003.
- src 0 (cause 2) and src 2 (cause 11) valid together -> src 0 taken with mcause 2. src 2 stays valid and is taken right after the return to IDLE with mcause 11; two cmt_csr pulses in total.
- irq_vld with cause 7, mtvec 32'h1001 -> mcause 32'h8000_0007, mtval 0, op1 32'h101C. Same case with mtvec 32'h1000 -> op1 32'h1000.
- ebreak with cause 3, dcsr_ebreakm=1, d_mode=0 -> op1 32'h800; cmt_dcsr pulse, dpc = pc, no cmt_csr. With d_mode=1 -> op1 32'h808 and cmt_csr pulse.
- ack held low for 5 cycles while the sources toggle -> req, op1 and cmt_* stay stable, all rdy=0, no commit pulse until ack.
- reset_n low during FLUSH -> req=0, busy=0 immediately, no cmt pulse; a new request is accepted normally after release.

Source files
------------

// File: rtl/lnrv_exu_excp_arb.sv
// lnrv_exu_excp_arb
//   Registered exception/interrupt arbiter for the lnrv EXU.
//   In IDLE it picks one winner: the lowest-index valid exception source,
//   or the interrupt when no exception is valid. It accepts the winner with
//   a one-cycle rdy and captures the trap context into holding registers.
//   In FLUSH it holds a pipeline flush request until it is acknowledged.
//   On the handshake it pulses either the M-mode CSR commit or, for an
//   ebreak that enters debug mode, the dcsr/dpc commit.
//
// Ports
//   clk, reset_n                       clock, async active-low reset
//   src_excp_{vld,rdy,cause,tval,ebreak} per-source exception request
//   irq_{vld,rdy,cause}                interrupt request
//   pc, d_mode, dcsr_ebreakm, mtvec    core context sampled at capture
//   cmt_csr/mepc/mcause/mtval          M-mode trap CSR update (pulse + data)
//   cmt_dcsr/dpc/dcause                debug-entry CSR update (pulse + data)
//   pipe_flush_{req,ack,pc_op1,pc_op2} flush handshake and target
//   busy                               arbiter is not IDLE
module lnrv_exu_excp_arb #(
  parameter int               NUM_SRC   = 3,
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  DBG_ENTRY = 32'h800,
  parameter logic [XLEN-1:0]  DBG_EXCP  = 32'h808
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SRC-1:0]      src_excp_vld,
  output logic [NUM_SRC-1:0]      src_excp_rdy,
  input  logic [4*NUM_SRC-1:0]    src_excp_cause,
  input  logic [XLEN*NUM_SRC-1:0] src_excp_tval,
  input  logic [NUM_SRC-1:0]      src_excp_ebreak,
  input  logic                    irq_vld,
  output logic                    irq_rdy,
  input  logic [3:0]              irq_cause,
  input  logic [XLEN-1:0]         pc,
  input  logic                    d_mode,
  input  logic                    dcsr_ebreakm,
  input  logic [XLEN-1:0]         mtvec,
  output logic                    cmt_csr,
  output logic [XLEN-1:0]         cmt_mepc,
  output logic [XLEN-1:0]         cmt_mcause,
  output logic [XLEN-1:0]         cmt_mtval,
  output logic                    cmt_dcsr,
  output logic [XLEN-1:0]         cmt_dpc,
  output logic [2:0]              cmt_dcause,
  output logic                    pipe_flush_req,
  input  logic                    pipe_flush_ack,
  output logic [XLEN-1:0]         pipe_flush_pc_op1,
  output logic [XLEN-1:0]         pipe_flush_pc_op2,
  output logic                    busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] grant;
  logic               win_vld, win_intr, win_ebrk, win_dbg;
  logic [3:0]         win_code;
  logic [XLEN-1:0]    win_tval, win_tgt, vec_base;

  // holding registers
  logic [XLEN-1:0]    pc_q, tval_q, tgt_q;
  logic [3:0]         code_q;
  logic               intr_q, dbg_q;

  logic idle, cap, hs;

  // Priority pick: first valid source from index 0 up. The interrupt only
  // wins when no exception is pending, and it never sets a source grant bit.
  always_comb begin
    grant    = '0;
    win_vld  = 1'b0;
    win_intr = 1'b0;
    win_ebrk = 1'b0;
    win_code = 4'd0;
    win_tval = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_vld && src_excp_vld[i]) begin
        grant[i] = 1'b1;
        win_vld  = 1'b1;
        win_code = src_excp_cause[4*i +: 4];
        win_tval = src_excp_tval[XLEN*i +: XLEN];
        win_ebrk = src_excp_ebreak[i];
      end
    end
    if (!win_vld && irq_vld) begin
      win_vld  = 1'b1;
      win_intr = 1'b1;
      win_code = irq_cause;
    end
  end

  assign win_dbg  = win_ebrk & ~d_mode & dcsr_ebreakm;
  assign vec_base = {mtvec[XLEN-1:2], 2'b00};

  // Vectored mode only redirects interrupts; exceptions use the base.
  always_comb begin
    win_tgt = vec_base;
    if (win_dbg)
      win_tgt = DBG_ENTRY;
    else if (d_mode)
      win_tgt = DBG_EXCP;
    else if (win_intr && mtvec[1:0] == 2'b01)
      win_tgt = vec_base + (XLEN'(win_code) << 2);
  end

  assign idle = (state_q == IDLE);
  assign cap  = idle & win_vld;
  assign hs   = (state_q == FLUSH) & pipe_flush_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld)        state_d = FLUSH;
      FLUSH:   if (pipe_flush_ack) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      tval_q  <= '0;
      tgt_q   <= '0;
      code_q  <= 4'd0;
      intr_q  <= 1'b0;
      dbg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        pc_q   <= pc;
        tval_q <= win_intr ? '0 : win_tval;
        tgt_q  <= win_tgt;
        code_q <= win_code;
        intr_q <= win_intr;
        dbg_q  <= win_dbg;
      end
    end
  end

  assign src_excp_rdy      = idle ? grant : '0;
  assign irq_rdy           = idle & win_intr;

  assign busy              = ~idle;
  assign pipe_flush_req    = ~idle;
  assign pipe_flush_pc_op1 = tgt_q;
  assign pipe_flush_pc_op2 = '0;

  assign cmt_csr    = hs & ~dbg_q;
  assign cmt_dcsr   = hs &  dbg_q;
  assign cmt_mepc   = pc_q;
  assign cmt_mcause = {intr_q, {(XLEN-5){1'b0}}, code_q};
  assign cmt_mtval  = tval_q;
  assign cmt_dpc    = pc_q;
  assign cmt_dcause = 3'd2;

endmodule

// File: tb/tb_lnrv_exu_excp_arb.sv
// Directed bench for lnrv_exu_excp_arb. Inputs change 1ns after the rising
// edge; outputs are checked 1ns after that, well away from the edge.
module tb_lnrv_exu_excp_arb;
  localparam int NS = 3;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NS-1:0]   src_excp_vld, src_excp_rdy, src_excp_ebreak;
  logic [4*NS-1:0] src_excp_cause;
  logic [XL*NS-1:0] src_excp_tval;
  logic            irq_vld, irq_rdy;
  logic [3:0]      irq_cause;
  logic [XL-1:0]   pc, mtvec;
  logic            d_mode, dcsr_ebreakm;
  logic            cmt_csr, cmt_dcsr;
  logic [XL-1:0]   cmt_mepc, cmt_mcause, cmt_mtval, cmt_dpc;
  logic [2:0]      cmt_dcause;
  logic            pipe_flush_req, pipe_flush_ack, busy;
  logic [XL-1:0]   pipe_flush_pc_op1, pipe_flush_pc_op2;

  int n_chk  = 0;
  int n_fail = 0;

  lnrv_exu_excp_arb #(.NUM_SRC(NS), .XLEN(XL)) dut (
    .clk(clk), .reset_n(reset_n),
    .src_excp_vld(src_excp_vld), .src_excp_rdy(src_excp_rdy),
    .src_excp_cause(src_excp_cause), .src_excp_tval(src_excp_tval),
    .src_excp_ebreak(src_excp_ebreak),
    .irq_vld(irq_vld), .irq_rdy(irq_rdy), .irq_cause(irq_cause),
    .pc(pc), .d_mode(d_mode), .dcsr_ebreakm(dcsr_ebreakm), .mtvec(mtvec),
    .cmt_csr(cmt_csr), .cmt_mepc(cmt_mepc), .cmt_mcause(cmt_mcause),
    .cmt_mtval(cmt_mtval), .cmt_dcsr(cmt_dcsr), .cmt_dpc(cmt_dpc),
    .cmt_dcause(cmt_dcause),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_pc_op1(pipe_flush_pc_op1), .pipe_flush_pc_op2(pipe_flush_pc_op2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [3:0] c, input logic [31:0] tv, input logic eb);
    src_excp_cause[4*i +: 4]  = c;
    src_excp_tval[XL*i +: XL] = tv;
    src_excp_ebreak[i]        = eb;
  endtask

  initial begin
    reset_n = 1'b0;
    src_excp_vld = '0; src_excp_cause = '0; src_excp_tval = '0; src_excp_ebreak = '0;
    irq_vld = 1'b0; irq_cause = 4'd0; pc = '0; mtvec = '0;
    d_mode = 1'b0; dcsr_ebreakm = 1'b0; pipe_flush_ack = 1'b0;
    step(); step();
    // reset state
    chk("rst_req",    pipe_flush_req, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_csr",    cmt_csr, 0);
    chk("rst_dcsr",   cmt_dcsr, 0);
    chk("rst_dcause", cmt_dcause, 3'd2);
    chk("rst_op1",    pipe_flush_pc_op1, 0);
    chk("rst_mepc",   cmt_mepc, 0);
    reset_n = 1'b1;
    step();

    // ack while idle is ignored
    pipe_flush_ack = 1'b1;
    step();
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_csr",  cmt_csr, 0);
    pipe_flush_ack = 1'b0;

    // T1: only src1
    pc = 32'h200; mtvec = 32'h1000;
    set_src(1, 4'd4, 32'h1003, 1'b0);
    src_excp_vld = 3'b010;
    #1;
    chk("t1_rdy", src_excp_rdy, 3'b010);
    chk("t1_req0", pipe_flush_req, 0);
    step();
    src_excp_vld = '0;
    pipe_flush_ack = 1'b1;
    #1;
    chk("t1_rdy_flush", src_excp_rdy, 0);
    chk("t1_req", pipe_flush_req, 1);
    chk("t1_op1", pipe_flush_pc_op1, 32'h1000);
    chk("t1_op2", pipe_flush_pc_op2, 0);
    chk("t1_csr", cmt_csr, 1);
    chk("t1_dcsr", cmt_dcsr, 0);
    chk("t1_mepc", cmt_mepc, 32'h200);
    chk("t1_mcause", cmt_mcause, 32'd4);
    chk("t1_mtval", cmt_mtval, 32'h1003);
    step();
    pipe_flush_ack = 1'b0;
    #1;
    chk("t1_req_off", pipe_flush_req, 0);
    chk("t1_csr_off", cmt_csr, 0);

    // T2: src0 and src2 together; src0 first, src2 right after
    set_src(0, 4'd2, 32'hA0, 1'b0);
    set_src(2, 4'd11, 32'hA2, 1'b0);
    pc = 32'h240;
    src_excp_vld = 3'b101;
    #1;
    chk("t2_rdy0", src_excp_rdy, 3'b001);
    step();
    src_excp_vld = 3'b100;
    pipe_flush_ack = 1'b1;
    #1;
    chk("t2_mcause0", cmt_mcause, 32'd2);
    chk("t2_mtval0",  cmt_mtval, 32'hA0);
    chk("t2_csr0", cmt_csr, 1);
    step();
    chk("t2_busy_idle", busy, 0);
    chk("t2_rdy2", src_excp_rdy, 3'b100);
    step();
    src_excp_vld = '0;
    #1;
    chk("t2_mcause2", cmt_mcause, 32'd11);
    chk("t2_mtval2",  cmt_mtval, 32'hA2);
    chk("t2_csr2", cmt_csr, 1);
    step();
    pipe_flush_ack = 1'b0;
    #1;
    chk("t2_idle", busy, 0);

    // T3: interrupt, vectored then direct
    for (int k = 0; k < 2; k++) begin
      mtvec = (k == 0) ? 32'h1001 : 32'h1000;
      pc = 32'h300 + k;
      irq_cause = 4'd7; irq_vld = 1'b1;
      #1;
      chk("t3_irq_rdy", irq_rdy, 1);
      chk("t3_src_rdy", src_excp_rdy, 0);
      step();
      irq_vld = 1'b0;
      pipe_flush_ack = 1'b1;
      #1;
      chk("t3_irq_rdy_flush", irq_rdy, 0);
      chk("t3_mcause", cmt_mcause, 32'h8000_0007);
      chk("t3_mtval", cmt_mtval, 0);
      chk("t3_op1", pipe_flush_pc_op1, (k == 0) ? 32'h101C : 32'h1000);
      chk("t3_mepc", cmt_mepc, 32'h300 + k);
      chk("t3_csr", cmt_csr, 1);
      step();
      pipe_flush_ack = 1'b0;
    end

    // exception beats interrupt
    irq_vld = 1'b1; src_excp_vld = 3'b100;
    #1;
    chk("pri_src_rdy", src_excp_rdy, 3'b100);
    chk("pri_irq_rdy", irq_rdy, 0);
    irq_vld = 1'b0; src_excp_vld = '0;
    #1;

    // T4: ebreak, debug entry then inside debug mode
    mtvec = 32'h1000; dcsr_ebreakm = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d_mode = (k == 1);
      pc = 32'h400 + 4*k;
      set_src(0, 4'd3, 32'h0, 1'b1);
      src_excp_vld = 3'b001;
      step();
      src_excp_vld = '0; src_excp_ebreak = '0;
      pipe_flush_ack = 1'b1;
      #1;
      chk("t4_op1", pipe_flush_pc_op1, (k == 0) ? 32'h800 : 32'h808);
      chk("t4_dcsr", cmt_dcsr, (k == 0));
      chk("t4_csr", cmt_csr, (k == 1));
      chk("t4_dpc", cmt_dpc, 32'h400 + 4*k);
      chk("t4_dcause", cmt_dcause, 3'd2);
      step();
      pipe_flush_ack = 1'b0;
    end
    d_mode = 1'b0; dcsr_ebreakm = 1'b0;

    // T5: ack delayed 5 cycles while inputs toggle
    pc = 32'h500;
    set_src(2, 4'd6, 32'h5555, 1'b0);
    src_excp_vld = 3'b100;
    step();
    for (int k = 0; k < 5; k++) begin
      src_excp_vld = 3'($urandom_range(1, 7));
      irq_vld = k[0];
      pc = $urandom;
      set_src(2, 4'($urandom), $urandom, 1'b0);
      mtvec = 32'h2001;
      #1;
      chk("t5_req", pipe_flush_req, 1);
      chk("t5_op1", pipe_flush_pc_op1, 32'h1000);
      chk("t5_mepc", cmt_mepc, 32'h500);
      chk("t5_mcause", cmt_mcause, 32'd6);
      chk("t5_mtval", cmt_mtval, 32'h5555);
      chk("t5_rdy", {src_excp_rdy, irq_rdy}, 0);
      chk("t5_csr", cmt_csr, 0);
      step();
    end
    src_excp_vld = '0; irq_vld = 1'b0; mtvec = 32'h1000;
    pipe_flush_ack = 1'b1;
    #1;
    chk("t5_csr_ack", cmt_csr, 1);
    chk("t5_mepc_ack", cmt_mepc, 32'h500);
    step();
    pipe_flush_ack = 1'b0;

    // T6: reset mid-flush aborts, then normal operation resumes
    pc = 32'h600;
    set_src(1, 4'd5, 32'h66, 1'b0);
    src_excp_vld = 3'b010;
    step();
    src_excp_vld = '0;
    chk("t6_req_pre", pipe_flush_req, 1);
    pipe_flush_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t6_req_rst", pipe_flush_req, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_csr_rst", cmt_csr, 0);
    chk("t6_mepc_rst", cmt_mepc, 0);
    step();
    pipe_flush_ack = 1'b0;
    reset_n = 1'b1;
    step();
    pc = 32'h680;
    set_src(1, 4'd1, 32'h68, 1'b0);
    src_excp_vld = 3'b010;
    #1;
    chk("t6_rdy_new", src_excp_rdy, 3'b010);
    step();
    src_excp_vld = '0;
    pipe_flush_ack = 1'b1;
    #1;
    chk("t6_csr_new", cmt_csr, 1);
    chk("t6_mepc_new", cmt_mepc, 32'h680);
    chk("t6_mcause_new", cmt_mcause, 32'd1);
    step();
    pipe_flush_ack = 1'b0;
    #1;
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
